// File: rtl/ruhman_btn.sv
// ruhman_btn: W-bit debouncer with sticky rise/fall event registers; RUHMAN_BTN_IRQ_EN adds a masked irq.
// Latency 2+max(thr,1) cycles din->level; the register slot never stalls, and reads are combinational.
module ruhman_btn #(
    parameter int W          = 16,
    parameter int DB_DEFAULT = 1_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
`ifdef RUHMAN_BTN_IRQ_EN
    output logic         irq,
`endif
    input  logic [W-1:0] din
);

    localparam logic [19:0] THR_RST = 20'(DB_DEFAULT);

    logic [W-1:0] sync1_q, sync2_q;
    logic [W-1:0] level_q, level_d;
    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic [19:0]  cnt_q [W];
    logic [19:0]  cnt_d [W];
    logic [19:0]  thr_q, thr_d;
    logic [20:0]  thr_eff;
    logic         wr_en;
    logic [W-1:0] wr_bits;
    logic         unused_ok;

    assign wr_en     = cs & write;
    assign wr_bits   = wr_data[W-1:0];
    assign unused_ok = &{1'b0, read, wr_data};
    assign thr_eff   = (thr_q == '0) ? 21'd1 : {1'b0, thr_q};

    // The counter never stores the terminal count: hitting it flips the level and clears.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (({1'b0, cnt_q[i]} + 21'd1) >= thr_eff) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
    end

    // New events are ORed in after the write-1 clear so a same-cycle set survives.
    always_comb begin
        rise_d = rise_q & ~((wr_en && addr == 5'd1) ? wr_bits : '0);
        fall_d = fall_q & ~((wr_en && addr == 5'd2) ? wr_bits : '0);
        rise_d = rise_d | (level_d & ~level_q);
        fall_d = fall_d | (~level_d & level_q);
        thr_d  = (wr_en && addr == 5'd3) ? wr_data[19:0] : thr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            thr_q   <= THR_RST;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            thr_q   <= thr_d;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef RUHMAN_BTN_IRQ_EN
    logic [W-1:0] mask_q;
    logic         irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && addr == 5'd4) begin
                mask_q <= wr_bits;
            end
            irq_q <= |((rise_q | fall_q) & mask_q);
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: rd_data[W-1:0] = level_q;
            5'd1: rd_data[W-1:0] = rise_q;
            5'd2: rd_data[W-1:0] = fall_q;
            5'd3: rd_data[19:0]  = thr_q;
`ifdef RUHMAN_BTN_IRQ_EN
            5'd4: rd_data[W-1:0] = mask_q;
`endif
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_ruhman_btn.sv
// Directed and randomized bench for ruhman_btn against a window-based debounce model.
module tb_ruhman_btn;
    localparam int W     = 16;
    localparam int TB_DB = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs, read, write;
    logic [4:0]   addr;
    logic [31:0]  wr_data, rd_data;
    logic [W-1:0] din;
`ifdef RUHMAN_BTN_IRQ_EN
    logic         irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ruhman_btn #(.W(W), .DB_DEFAULT(TB_DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
`ifdef RUHMAN_BTN_IRQ_EN
        .irq     (irq),
`endif
        .din     (din)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step();
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    initial begin
        logic [31:0]  v;
        logic [W-1:0] mlevel, mrise, mfall, r;
        logic [W-1:0] hist [$];
        int           te, n;
        logic         flip;

        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; din = '0;
        step(); step();
        rd(5'd0, v); chk("rst_level", v, 32'h0);
        rd(5'd3, v); chk("rst_thr", v, TB_DB);
        reset = 1'b0;
        step();
        rd(5'd1, v); chk("rst_rise", v, 32'h0);
        rd(5'd2, v); chk("rst_fall", v, 32'h0);

        // Threshold 5: bit0 rises exactly 7 edges after din changes.
        wr(5'd3, 32'd5);
        din[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            rd(5'd0, v); chk("lat7_bit0", {31'b0, v[0]}, (k >= 7));
        end
        rd(5'd1, v); chk("lat7_rise", v, 32'h1);
        rd(5'd2, v); chk("lat7_fall", v, 32'h0);

        // A 4-cycle glitch on bit3 must be filtered out.
        din[3] = 1'b1;
        repeat (4) step();
        din[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            rd(5'd0, v); chk("glitch_level", v, 32'h1);
            rd(5'd1, v); chk("glitch_rise", v, 32'h1);
        end

        // Same-cycle rise event and write-1 clear: the event wins.
        din[0] = 1'b0;
        repeat (10) step();
        rd(5'd0, v); chk("fall_level", v, 32'h0);
        rd(5'd2, v); chk("fall_bit0", v, 32'h1);
        din[0] = 1'b1;
        repeat (6) step();
        cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'h1;
        step();
        cs = 1'b0; write = 1'b0; wr_data = '0;
        rd(5'd0, v); chk("coll_level", v, 32'h1);
        rd(5'd1, v); chk("coll_rise", v, 32'h1);
        wr(5'd1, 32'h1);
        rd(5'd1, v); chk("clr_rise", v, 32'h0);
        wr(5'd2, 32'hFFFF);
        rd(5'd2, v); chk("clr_fall", v, 32'h0);

        wr(5'd0, 32'hFFFF);
        rd(5'd0, v); chk("ro_level", v, 32'h1);
        wr(5'd7, 32'hFFFF);
        rd(5'd7, v); chk("unmapped", v, 32'h0);
`ifdef RUHMAN_BTN_IRQ_EN
        wr(5'd4, 32'hFFFF_FFFF);
        rd(5'd4, v); chk("mask_rw", v, 32'hFFFF);
        wr(5'd4, 32'h0);
`else
        wr(5'd4, 32'hFFFF);
        rd(5'd4, v); chk("addr4_off", v, 32'h0);
`endif

        // Threshold 0 behaves as 1: 3-edge latency both directions.
        wr(5'd3, 32'd0);
        rd(5'd3, v); chk("thr0_read", v, 32'h0);
        din[15] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            rd(5'd0, v); chk("thr0_up", {31'b0, v[15]}, (k >= 3));
        end
        din[15] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            rd(5'd0, v); chk("thr0_down", {31'b0, v[15]}, (k < 3));
        end
        rd(5'd1, v); chk("thr0_rise", v, 32'h8000);
        rd(5'd2, v); chk("thr0_fall", v, 32'h8000);

        // Reset mid-count abandons the interval; no events from reset.
        wr(5'd3, 32'd5);
        wr(5'd1, 32'hFFFF);
        wr(5'd2, 32'hFFFF);
        din[2] = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        #1;
        rd(5'd0, v); chk("inrst_level", v, 32'h0);
        rd(5'd2, v); chk("inrst_fall", v, 32'h0);
        step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            rd(5'd0, v); chk("post_rst_level", v, (k >= 7) ? 32'h5 : 32'h0);
        end
        rd(5'd1, v); chk("post_rst_rise", v, 32'h5);
        rd(5'd2, v); chk("post_rst_fall", v, 32'h0);

`ifdef RUHMAN_BTN_IRQ_EN
        wr(5'd1, 32'hFFFF);
        wr(5'd4, 32'h2);
        step();
        chk("irq_idle", {31'b0, irq}, 32'h0);
        din[1] = 1'b1;
        repeat (7) step();
        chk("irq_event_edge", {31'b0, irq}, 32'h0);
        step();
        chk("irq_set", {31'b0, irq}, 32'h1);
        wr(5'd1, 32'h2);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        step();
        chk("irq_clr", {31'b0, irq}, 32'h0);
        din[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("irq_masked", {31'b0, irq}, 32'h0);
        end
        rd(5'd2, v); chk("irq_fall0", v, 32'h1);
        wr(5'd4, 32'h0);
`endif

        // Random phase: level flips once the synced input has disagreed for te consecutive edges.
        for (int pass = 0; pass < 2; pass++) begin
            din = '0;
            reset = 1'b1;
            step();
            reset = 1'b0;
            te = $urandom_range(0, 4);
            wr(5'd3, te);
            if (te == 0) te = 1;
            hist.delete();
            mlevel = '0; mrise = '0; mfall = '0;
            for (int c = 0; c < 400; c++) begin
                r = W'($urandom) & W'($urandom) & W'($urandom);
                din = din ^ r;
                hist.push_back(din);
                step();
                n = hist.size() - 1;
                if (n - 1 - te >= 0) begin
                    for (int b = 0; b < W; b++) begin
                        flip = 1'b1;
                        for (int k = n - 1 - te; k <= n - 2; k++) begin
                            if (hist[k][b] == mlevel[b]) flip = 1'b0;
                        end
                        if (flip) begin
                            mlevel[b] = ~mlevel[b];
                            if (mlevel[b]) mrise[b] = 1'b1;
                            else           mfall[b] = 1'b1;
                        end
                    end
                end
                rd(5'd0, v); chk("rnd_level", v, {16'b0, mlevel});
                if (c % 50 == 49) begin
                    rd(5'd1, v); chk("rnd_rise", v, {16'b0, mrise});
                    rd(5'd2, v); chk("rnd_fall", v, {16'b0, mfall});
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ruhman_btn.md
RUHMAN_BTN -- requirements
Module: ruhman_btn

Interface
REQ-001 Parameter W, default 16: number of input bits debounced and monitored.
REQ-002 Parameter DB_DEFAULT, default 1_000_000: reset value of the debounce threshold (10 ms at 100 MHz).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  slot select.
REQ-006 read  input  1  slot read strobe; informational only, reads have no side effects.
REQ-007 write  input  1  slot write strobe; a write is accepted only when cs && write.
REQ-008 addr  input  5  register address.
REQ-009 wr_data  input  32  write data.
REQ-010 rd_data  output  32  read data.
REQ-011 din  input  W  raw asynchronous switch/button inputs.

Function
REQ-012 Each din bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL have an independent 20-bit stability counter:
- Clears to 0 whenever the synced bit equals the debounced bit.
- Otherwise increments each cycle.
- When the increment would reach the threshold, the debounced bit takes the synced value and the counter clears in the same cycle.
REQ-014 A threshold register value of 0 SHALL behave as 1. The total latency from a stable din change to the debounced bit update is therefore 2 + max(thr,1) cycles.
REQ-015 A 0->1 transition of a debounced bit SHALL set the corresponding bit of the rise register; a 1->0 transition SHALL set the corresponding bit of the fall register. Both registers are sticky.
REQ-016 Register map; rd_data is combinational on addr and does not depend on cs or read; bits above W and unused bits read 0:
- addr 0: debounced level, read-only.
- addr 1: rise events; a write clears each bit where wr_data is 1.
- addr 2: fall events; a write clears each bit where wr_data is 1.
- addr 3: threshold wr_data[19:0], read/write.
- any other addr: reads 0, writes ignored.
REQ-017 If an event set and a write-1 clear hit the same bit in the same cycle, the set SHALL win.
REQ-018 Writing the threshold SHALL take effect on the next cycle and SHALL NOT clear in-progress counters. A counter already at or above the new threshold SHALL update its debounced bit on its next mismatching cycle.
REQ-019 Writes to addr 0 SHALL be ignored.

Reset
REQ-020 Reset SHALL clear all of the following to 0: synchronizer flops, debounced levels, counters, rise register and fall register.
REQ-021 Reset SHALL load the threshold with DB_DEFAULT[19:0].
REQ-022 rd_data SHALL read 0 at addresses 0-2 during reset. No event SHALL be generated by reset itself or by its release.
REQ-023 Reset asserted mid-debounce SHALL abandon the count; the debounced level stays 0 until a fresh full stable interval completes after release.

Configuration
REQ-024 Macro RUHMAN_BTN_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), registered, 0 in reset.
  - irq = OR over bits of ((rise | fall) & mask), updated one cycle after any event or mask change.
  - Adds the interrupt mask at addr 4 (W bits, read/write, reset 0).
- Undefined:
  - No irq port.
  - addr 4 reads 0 and writes to it are ignored.

Verification
REQ-025 Write 5 to addr 3; din[0]=1 held -> addr 0 bit0 becomes 1 exactly 7 cycles after the din edge; addr 1 reads 0x0001.
REQ-026 Threshold 5; din[3] pulses 1 for 4 cycles then 0 -> addr 0 and addr 1 remain 0 throughout.
REQ-027 Rise bit0 set; write 0x0001 to addr 1 in the same cycle a new bit0 rise occurs -> addr 1 still reads 0x0001. Next cycle, write 0x0001 with no event -> addr 1 reads 0.
REQ-028 Threshold 0; din[15] 0->1->0, each level held 10 cycles -> level bit15 toggles 3 cycles after each edge; addr 1 = addr 2 = 0x8000.
REQ-029 Assert reset while a bit has counted 3 of 5 -> after release, level stays 0 until 7 further stable cycles; no event bits set by reset.
REQ-030 With RUHMAN_BTN_IRQ_EN: mask 0x0002, event on bit1 -> irq=1 one cycle after the event; clear addr 2/addr 1 -> irq=0 next cycle. An event on bit0 only -> irq stays 0.
